// File: rtl/ser_param_4f.sv
// ser_param_4f: parallel-to-serial slicer on the fast PHY clock.
// Accepts IN_W-bit words through valid/ready and buffers one word. Each word
// is emitted as RATIO = IN_W/OUT_W slices, one per cycle. Consecutive words
// stream with no idle gap. A synchronous abort discards in-flight data.
module ser_param_4f #(
    parameter int               IN_W      = 32,
    parameter int               OUT_W     = 8,
    parameter bit               MSB_FIRST = 1'b1,
    parameter logic [OUT_W-1:0] IDLE_WORD = '0
) (
    input  logic             clk_4f,
    input  logic             reset,
    input  logic [IN_W-1:0]  data_in,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             abort,
    output logic [OUT_W-1:0] data_out,
    output logic             valid_out,
    output logic             sof,
    output logic             eow
);

    localparam int RATIO = IN_W / OUT_W;
    localparam int CW    = $clog2(RATIO);
    localparam logic [CW-1:0] LAST = CW'(RATIO - 1);

    typedef enum logic {
        S_IDLE,
        S_STREAM
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [IN_W-1:0]   hold_q, hold_d;
    logic              hold_valid_q, hold_valid_d;
    logic [IN_W-1:0]   shift_q, shift_d;
    logic [OUT_W-1:0]  data_out_q, data_out_d;
    logic              valid_q, valid_d;
    logic              sof_q, sof_d;
    logic              eow_q, eow_d;

    logic              accept;
    logic              last_slice;
    logic [CW-1:0]     cnt_inc;

    // Slice idx of word w, in the configured transmit order.
    function automatic logic [OUT_W-1:0] slice_of(input logic [IN_W-1:0] w,
                                                  input logic [CW-1:0]   idx);
        int base;
        base = (MSB_FIRST ? (RATIO - 1 - int'(idx)) : int'(idx)) * OUT_W;
        return w[base +: OUT_W];
    endfunction

    // Abort blocks acceptance for its edge even though in_ready is flop-driven.
    assign in_ready   = ~hold_valid_q;
    assign accept     = in_valid & ~hold_valid_q & ~abort;
    assign last_slice = (cnt_q == LAST);
    assign cnt_inc    = cnt_q + 1'b1;

    // Next-state logic: abort, then stream the next slice, then load, else idle.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        hold_d       = hold_q;
        hold_valid_d = hold_valid_q;
        shift_d      = shift_q;
        data_out_d   = IDLE_WORD;
        valid_d      = 1'b0;
        sof_d        = 1'b0;
        eow_d        = 1'b0;

        if (accept) begin
            hold_d       = data_in;
            hold_valid_d = 1'b1;
        end

        if (abort) begin
            state_d      = S_IDLE;
            cnt_d        = '0;
            hold_valid_d = 1'b0;
        end else if (state_q == S_STREAM && !last_slice) begin
            cnt_d      = cnt_inc;
            data_out_d = slice_of(shift_q, cnt_inc);
            valid_d    = 1'b1;
            eow_d      = (cnt_inc == LAST);
        end else if (hold_valid_q) begin
            shift_d      = hold_q;
            data_out_d   = slice_of(hold_q, '0);
            cnt_d        = '0;
            state_d      = S_STREAM;
            hold_valid_d = 1'b0;
            valid_d      = 1'b1;
            sof_d        = 1'b1;
        end else begin
            state_d = S_IDLE;
        end
    end

    // Control and output registers with synchronous active-low reset.
    always_ff @(posedge clk_4f) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            hold_valid_q <= 1'b0;
            data_out_q   <= IDLE_WORD;
            valid_q      <= 1'b0;
            sof_q        <= 1'b0;
            eow_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            hold_valid_q <= hold_valid_d;
            data_out_q   <= data_out_d;
            valid_q      <= valid_d;
            sof_q        <= sof_d;
            eow_q        <= eow_d;
        end
    end

    // Data holding registers; contents only matter while qualified by flags.
    always_ff @(posedge clk_4f) begin
        hold_q  <= hold_d;
        shift_q <= shift_d;
    end

    assign data_out  = data_out_q;
    assign valid_out = valid_q;
    assign sof       = sof_q;
    assign eow       = eow_q;

endmodule

// File: tb/tb_ser_param_4f.sv
// Testbench for ser_param_4f: two instances (32->8 MSB-first, 64->16
// LSB-first) checked every cycle against a schedule-based reference model.
module tb_ser_param_4f;

    localparam int R = 4;

    logic        clk_4f = 1'b0;
    logic        reset;
    logic        in_valid_v [2];
    logic        abort_v    [2];
    logic [63:0] data_v     [2];

    logic        in_ready0, in_ready1;
    logic        valid0, valid1, sof0, sof1, eow0, eow1;
    logic [7:0]  dout0;
    logic [15:0] dout1;

    always #5 clk_4f = ~clk_4f;

    ser_param_4f u_dut0 (
        .clk_4f   (clk_4f),
        .reset    (reset),
        .data_in  (data_v[0][31:0]),
        .in_valid (in_valid_v[0]),
        .in_ready (in_ready0),
        .abort    (abort_v[0]),
        .data_out (dout0),
        .valid_out(valid0),
        .sof      (sof0),
        .eow      (eow0)
    );

    ser_param_4f #(
        .IN_W     (64),
        .OUT_W    (16),
        .MSB_FIRST(1'b0),
        .IDLE_WORD(16'hA5A5)
    ) u_dut1 (
        .clk_4f   (clk_4f),
        .reset    (reset),
        .data_in  (data_v[1]),
        .in_valid (in_valid_v[1]),
        .in_ready (in_ready1),
        .abort    (abort_v[1]),
        .data_out (dout1),
        .valid_out(valid1),
        .sof      (sof1),
        .eow      (eow1)
    );

    // Reference model: each accepted word gets a start edge; its slices occupy
    // edges start..start+R-1. Start = max(accept+1, previous word end + 1).
    typedef struct {
        int          d;
        logic [63:0] w;
        int          s;
    } ent_t;

    ent_t sched[$];
    int   edge_n = 0;
    int   total  = 0;
    int   bad    = 0;
    bit   acc [2];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, edge_n);
        end
    endtask

    // Hold is occupied while some word has been accepted but not yet started.
    function automatic bit m_ready(input int d, input int e);
        foreach (sched[i])
            if (sched[i].d == d && sched[i].s > e) return 1'b0;
        return 1'b1;
    endfunction

    function automatic int m_last_end(input int d);
        int le = -1000;
        foreach (sched[i])
            if (sched[i].d == d && sched[i].s + R - 1 > le) le = sched[i].s + R - 1;
        return le;
    endfunction

    function automatic logic [15:0] m_slice(input int d, input logic [63:0] w, input int i);
        int          ow = (d != 0) ? 16 : 8;
        int          sh = (d == 0) ? (R - 1 - i) * ow : i * ow;
        logic [63:0] m  = (64'd1 << ow) - 64'd1;
        return 16'((w >> sh) & m);
    endfunction

    task automatic m_step(input int d);
        acc[d] = 1'b0;
        if (!reset || abort_v[d]) begin
            for (int i = sched.size() - 1; i >= 0; i--)
                if (sched[i].d == d && sched[i].s + R - 1 >= edge_n) sched.delete(i);
        end else if (in_valid_v[d] && m_ready(d, edge_n - 1)) begin
            ent_t en;
            int   st;
            st = m_last_end(d) + 1;
            if (st < edge_n + 1) st = edge_n + 1;
            en.d = d;
            en.w = data_v[d];
            en.s = st;
            sched.push_back(en);
            acc[d] = 1'b1;
        end
        for (int i = sched.size() - 1; i >= 0; i--)
            if (sched[i].d == d && sched[i].s + R - 1 < edge_n - 2) sched.delete(i);
    endtask

    task automatic m_compare(input int d);
        logic [15:0] xd = (d != 0) ? 16'hA5A5 : 16'h0000;
        bit          xv = 1'b0;
        bit          xs = 1'b0;
        bit          xe = 1'b0;
        foreach (sched[i]) begin
            if (sched[i].d == d && sched[i].s <= edge_n && edge_n <= sched[i].s + R - 1) begin
                xd = m_slice(d, sched[i].w, edge_n - sched[i].s);
                xv = 1'b1;
                xs = (edge_n == sched[i].s);
                xe = (edge_n == sched[i].s + R - 1);
            end
        end
        if (d == 0) begin
            check("d0.data_out",  64'(dout0),     64'(xd));
            check("d0.valid_out", 64'(valid0),    64'(xv));
            check("d0.sof",       64'(sof0),      64'(xs));
            check("d0.eow",       64'(eow0),      64'(xe));
            check("d0.in_ready",  64'(in_ready0), 64'(m_ready(0, edge_n)));
        end else begin
            check("d1.data_out",  64'(dout1),     64'(xd));
            check("d1.valid_out", 64'(valid1),    64'(xv));
            check("d1.sof",       64'(sof1),      64'(xs));
            check("d1.eow",       64'(eow1),      64'(xe));
            check("d1.in_ready",  64'(in_ready1), 64'(m_ready(1, edge_n)));
        end
    endtask

    task automatic cycle();
        @(posedge clk_4f);
        edge_n++;
        m_step(0);
        m_step(1);
        @(negedge clk_4f);
        m_compare(0);
        m_compare(1);
    endtask

    // Offer a word and hold it until the model says it was taken (bounded).
    task automatic offer(input int d, input logic [63:0] w);
        bit got = 1'b0;
        in_valid_v[d] = 1'b1;
        data_v[d]     = w;
        for (int n = 0; n < 20; n++) begin
            cycle();
            if (acc[d]) begin
                got = 1'b1;
                break;
            end
        end
        check("offer.accepted", 64'(got), 64'd1);
        in_valid_v[d] = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        for (int d = 0; d < 2; d++) begin
            in_valid_v[d] = 1'b0;
            abort_v[d]    = 1'b0;
            data_v[d]     = '0;
        end
        in_valid_v[0] = 1'b1;
        data_v[0]     = 64'hDEADBEEF;
        @(negedge clk_4f);
        repeat (3) cycle();
        reset         = 1'b1;
        in_valid_v[0] = 1'b0;

        // Single word, then back-to-back pair.
        offer(0, 64'hDEADBEEF);
        repeat (6) cycle();
        offer(0, 64'h11223344);
        offer(0, 64'h55667788);
        repeat (8) cycle();

        // Abort after the second slice with a word queued in hold.
        offer(0, 64'hAABBCCDD);
        offer(0, 64'h12345678);
        abort_v[0] = 1'b1;
        cycle();
        abort_v[0] = 1'b0;
        repeat (8) cycle();

        // Reset mid-word, then a fresh word.
        offer(0, 64'hCAFEF00D);
        repeat (3) cycle();
        reset = 1'b0;
        cycle();
        reset = 1'b1;
        offer(0, 64'h0BADC0DE);
        repeat (6) cycle();

        // LSB-first wide instance.
        offer(1, 64'h0001_0002_0003_0004);
        repeat (6) cycle();

        // Randomized traffic with occasional abort and reset.
        for (int n = 0; n < 3000; n++) begin
            for (int d = 0; d < 2; d++) begin
                if (!in_valid_v[d] || acc[d]) begin
                    in_valid_v[d] = ($urandom_range(0, 9) < 6);
                    data_v[d]     = {$urandom, $urandom};
                end
                abort_v[d] = ($urandom_range(0, 39) == 0);
            end
            reset = ($urandom_range(0, 199) != 0);
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
